// File: rtl/weight_update_bank.sv
// Double-buffered DPD weight store: saturating read-modify-write updates land in the
// shadow bank, commit swaps banks atomically and COPY resynchronises the new shadow.
module weight_update_bank #(
   parameter int WEIGHT_WIDTH = 16,
   parameter int NUM_WEIGHTS  = 1170,
   parameter int ADDR_WIDTH   = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    upd_valid,
   input  logic [ADDR_WIDTH-1:0]   upd_idx,
   input  logic [WEIGHT_WIDTH-1:0] upd_delta,
   output logic                    upd_ready,
   input  logic                    commit,
   input  logic                    rollback,
   input  logic                    ld_valid,
   input  logic [ADDR_WIDTH-1:0]   ld_addr,
   input  logic [WEIGHT_WIDTH-1:0] ld_data,
   input  logic [ADDR_WIDTH-1:0]   rd_addr,
   output logic [WEIGHT_WIDTH-1:0] rd_data,
   output logic                    bank_sel,
   output logic                    busy,
   output logic                    commit_done,
   output logic [ADDR_WIDTH-1:0]   update_count,
   output logic [ADDR_WIDTH-1:0]   sat_count,
   output logic                    idx_err
);

   localparam int MEM_AW = (NUM_WEIGHTS > 1) ? $clog2(NUM_WEIGHTS) : 1;
   localparam logic [ADDR_WIDTH-1:0]   NUM_A  = ADDR_WIDTH'(NUM_WEIGHTS);
   localparam logic [ADDR_WIDTH-1:0]   LAST_A = ADDR_WIDTH'(NUM_WEIGHTS - 1);
   localparam logic [ADDR_WIDTH-1:0]   ONE_A  = ADDR_WIDTH'(1);
   localparam logic [WEIGHT_WIDTH-1:0] W_MAX  = {1'b0, {(WEIGHT_WIDTH-1){1'b1}}};
   localparam logic [WEIGHT_WIDTH-1:0] W_MIN  = {1'b1, {(WEIGHT_WIDTH-1){1'b0}}};

   localparam logic [1:0] ST_INIT  = 2'd0;
   localparam logic [1:0] ST_IDLE  = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_COPY  = 2'd3;

   logic [1:0]            state_q, state_d;
   logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
   logic                  bank_sel_q, bank_sel_d;
   logic                  is_commit_q, is_commit_d;
   logic                  commit_done_q, commit_done_d;
   logic [ADDR_WIDTH-1:0] upd_cnt_q, upd_cnt_d;
   logic [ADDR_WIDTH-1:0] sat_cnt_q, sat_cnt_d;
   logic                  idx_err_q, idx_err_d;
   logic                  s2_valid_q;
   logic [WEIGHT_WIDTH-1:0] rd_data_q;

   // Pipeline datapath registers; qualified by s2_valid_q so they need no reset.
   logic                    s2_inrange_q;
   logic [ADDR_WIDTH-1:0]   s2_idx_q;
   logic [WEIGHT_WIDTH-1:0] s2_old_q;
   logic [WEIGHT_WIDTH-1:0] s2_delta_q;
   logic [WEIGHT_WIDTH-1:0] copy_data_q;

   logic [WEIGHT_WIDTH-1:0] mem_q [0:1][0:NUM_WEIGHTS-1];

   logic                  in_idle, upd_accept, ld_fire;
   logic                  upd_in_range, ld_in_range, rd_in_range, copy_rd_ok;
   logic                  s2_write, s2_clip, fwd_hit;
   logic [WEIGHT_WIDTH:0] s2_sum;
   logic [WEIGHT_WIDTH-1:0] s2_result;
   logic [ADDR_WIDTH-1:0] copy_wr_addr;

   assign in_idle      = (state_q == ST_IDLE);
   assign upd_in_range = (upd_idx < NUM_A);
   assign ld_in_range  = (ld_addr < NUM_A);
   assign rd_in_range  = (rd_addr < NUM_A);
   assign copy_rd_ok   = (cnt_q < NUM_A);
   assign upd_accept   = in_idle && !ld_valid && upd_valid;
   assign ld_fire      = in_idle && ld_valid;
   assign copy_wr_addr = cnt_q - ONE_A;

   // Sign-extend both operands by one bit; overflow shows as a top-two-bit mismatch.
   assign s2_sum    = {s2_old_q[WEIGHT_WIDTH-1], s2_old_q} + {s2_delta_q[WEIGHT_WIDTH-1], s2_delta_q};
   assign s2_clip   = s2_sum[WEIGHT_WIDTH] ^ s2_sum[WEIGHT_WIDTH-1];
   assign s2_result = s2_clip ? (s2_sum[WEIGHT_WIDTH] ? W_MIN : W_MAX) : s2_sum[WEIGHT_WIDTH-1:0];
   assign s2_write  = s2_valid_q && s2_inrange_q;
   assign fwd_hit   = s2_write && (s2_idx_q == upd_idx);

   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      bank_sel_d    = bank_sel_q;
      is_commit_d   = is_commit_q;
      commit_done_d = 1'b0;
      upd_cnt_d     = upd_cnt_q;
      sat_cnt_d     = sat_cnt_q;
      idx_err_d     = idx_err_q;

      if (s2_write && (upd_cnt_q != '1)) upd_cnt_d = upd_cnt_q + ONE_A;
      if (s2_write && s2_clip && (sat_cnt_q != '1)) sat_cnt_d = sat_cnt_q + ONE_A;
      if ((s2_valid_q && !s2_inrange_q) || (ld_fire && !ld_in_range)) idx_err_d = 1'b1;

      case (state_q)
         ST_INIT: begin
            cnt_d = cnt_q + ONE_A;
            if (cnt_q == LAST_A) begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         end
         ST_IDLE: begin
            if (commit || rollback) begin
               state_d     = ST_DRAIN;
               is_commit_d = !rollback;
            end
         end
         ST_DRAIN: begin
            state_d   = ST_COPY;
            cnt_d     = '0;
            upd_cnt_d = '0;
            if (is_commit_q) bank_sel_d = !bank_sel_q;
         end
         ST_COPY: begin
            cnt_d = cnt_q + ONE_A;
            if (cnt_q == NUM_A) begin
               state_d       = ST_IDLE;
               cnt_d         = '0;
               commit_done_d = 1'b1;
            end
         end
         default: state_d = ST_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_INIT;
         cnt_q         <= '0;
         bank_sel_q    <= 1'b0;
         is_commit_q   <= 1'b0;
         commit_done_q <= 1'b0;
         upd_cnt_q     <= '0;
         sat_cnt_q     <= '0;
         idx_err_q     <= 1'b0;
         s2_valid_q    <= 1'b0;
         rd_data_q     <= '0;
      end else begin
         // NOTE: every clocked register uses <= so all of them see pre-edge values.
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         bank_sel_q    <= bank_sel_d;
         is_commit_q   <= is_commit_d;
         commit_done_q <= commit_done_d;
         upd_cnt_q     <= upd_cnt_d;
         sat_cnt_q     <= sat_cnt_d;
         idx_err_q     <= idx_err_d;
         s2_valid_q    <= upd_accept;
         rd_data_q     <= rd_in_range ? mem_q[bank_sel_q][rd_addr[MEM_AW-1:0]] : '0;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: the banks are not reset here; INIT clears them one entry per cycle.
      if (!rst) begin
         if (state_q == ST_INIT) begin
            mem_q[0][cnt_q[MEM_AW-1:0]] <= '0;
            mem_q[1][cnt_q[MEM_AW-1:0]] <= '0;
         end
         if (ld_fire && ld_in_range) begin
            mem_q[0][ld_addr[MEM_AW-1:0]] <= ld_data;
            mem_q[1][ld_addr[MEM_AW-1:0]] <= ld_data;
         end
         if (s2_write)
            mem_q[!bank_sel_q][s2_idx_q[MEM_AW-1:0]] <= s2_result;
         if ((state_q == ST_COPY) && (cnt_q != '0))
            mem_q[!bank_sel_q][copy_wr_addr[MEM_AW-1:0]] <= copy_data_q;
      end
      copy_data_q  <= copy_rd_ok ? mem_q[bank_sel_q][cnt_q[MEM_AW-1:0]] : '0;
      // A same-index S2 result is being written this edge, so the RAM read is stale.
      s2_old_q     <= fwd_hit ? s2_result :
                      (upd_in_range ? mem_q[!bank_sel_q][upd_idx[MEM_AW-1:0]] : '0);
      s2_idx_q     <= upd_idx;
      s2_delta_q   <= upd_delta;
      s2_inrange_q <= upd_in_range;
   end

   assign upd_ready    = in_idle && !ld_valid;
   assign busy         = !in_idle;
   assign rd_data      = rd_data_q;
   assign bank_sel     = bank_sel_q;
   assign commit_done  = commit_done_q;
   assign update_count = upd_cnt_q;
   assign sat_count    = sat_cnt_q;
   assign idx_err      = idx_err_q;

endmodule

// File: tb/tb_weight_update_bank.sv
// Directed and randomized bench for weight_update_bank against a logical-bank model
// (active/shadow arrays, integer clamp arithmetic, counters kept as plain ints).
module tb_weight_update_bank;

   localparam int W = 16;
   localparam int N = 1170;
   localparam int A = 16;

   logic         clk = 1'b0;
   logic         rst;
   logic         upd_valid;
   logic [A-1:0] upd_idx;
   logic [W-1:0] upd_delta;
   logic         upd_ready;
   logic         commit;
   logic         rollback;
   logic         ld_valid;
   logic [A-1:0] ld_addr;
   logic [W-1:0] ld_data;
   logic [A-1:0] rd_addr;
   logic [W-1:0] rd_data;
   logic         bank_sel;
   logic         busy;
   logic         commit_done;
   logic [A-1:0] update_count;
   logic [A-1:0] sat_count;
   logic         idx_err;

   always #5 clk = ~clk;

   weight_update_bank #(.WEIGHT_WIDTH(W), .NUM_WEIGHTS(N), .ADDR_WIDTH(A)) dut (
      .clk(clk), .rst(rst),
      .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_delta(upd_delta), .upd_ready(upd_ready),
      .commit(commit), .rollback(rollback),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
      .rd_addr(rd_addr), .rd_data(rd_data),
      .bank_sel(bank_sel), .busy(busy), .commit_done(commit_done),
      .update_count(update_count), .sat_count(sat_count), .idx_err(idx_err)
   );

   int total = 0;
   int bad   = 0;

   // Reference model, indexed by logical role rather than physical bank.
   int m_act [N];
   int m_shd [N];
   int m_ucnt, m_scnt;
   bit m_err, m_bank;

   function automatic logic [W-1:0] w16(input int v);
      return W'(v);
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      upd_valid = 1'b0;
      repeat (n) tick();
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_act[i] = 0;
         m_shd[i] = 0;
      end
      m_ucnt = 0;
      m_scnt = 0;
      m_err  = 1'b0;
      m_bank = 1'b0;
   endtask

   task automatic wait_init();
      int n = 0;
      while (upd_ready !== 1'b1 && n < 3000) begin
         tick();
         n++;
      end
      check("init_len", n, N);
   endtask

   task automatic check_counters(input string tag);
      check({tag, "_ucnt"}, update_count, m_ucnt);
      check({tag, "_scnt"}, sat_count, m_scnt);
      check({tag, "_err"}, idx_err, m_err);
   endtask

   task automatic rd_check(input int addr);
      int exp;
      rd_addr = A'(addr);
      tick();
      exp = (addr < N) ? m_act[addr] : 0;
      check($sformatf("rd@%0d", addr), rd_data, w16(exp));
   endtask

   task automatic do_load(input int addr, input logic [W-1:0] data);
      ld_valid = 1'b1;
      ld_addr  = A'(addr);
      ld_data  = data;
      if (addr < N) begin
         m_act[addr] = int'($signed(data));
         m_shd[addr] = int'($signed(data));
      end else begin
         m_err = 1'b1;
      end
      tick();
      ld_valid = 1'b0;
   endtask

   // One accepted update beat; upd_valid stays high so beats can run back to back.
   task automatic upd_beat(input int idx, input logic [W-1:0] delta);
      int s;
      upd_valid = 1'b1;
      upd_idx   = A'(idx);
      upd_delta = delta;
      if (idx < N) begin
         s = m_shd[idx] + int'($signed(delta));
         if (s > 32767) begin
            s = 32767;
            if (m_scnt < 65535) m_scnt++;
         end else if (s < -32768) begin
            s = -32768;
            if (m_scnt < 65535) m_scnt++;
         end
         m_shd[idx] = s;
         if (m_ucnt < 65535) m_ucnt++;
      end else begin
         m_err = 1'b1;
      end
      tick();
   endtask

   task automatic do_commit(input bit rb, input bit both, input int probe, input bit poke);
      logic [W-1:0] old_exp;
      int lat;
      old_exp  = w16(m_act[probe]);
      rd_addr  = A'(probe);
      commit   = !rb || both;
      rollback = rb;
      tick();
      commit   = 1'b0;
      rollback = 1'b0;
      lat = 1;
      if (rb) begin
         for (int i = 0; i < N; i++) m_shd[i] = m_act[i];
      end else begin
         m_bank = !m_bank;
         for (int i = 0; i < N; i++) m_act[i] = m_shd[i];
      end
      m_ucnt = 0;
      check("c1_busy", busy, 1'b1);
      check("c1_ready", upd_ready, 1'b0);
      check("c1_rd_old", rd_data, old_exp);
      tick();
      lat++;
      check("c2_bank", bank_sel, m_bank);
      tick();
      lat++;
      check("c3_rd_new", rd_data, w16(m_act[probe]));
      if (poke) begin
         commit   = 1'b1;
         ld_valid = 1'b1;
         ld_addr  = A'(probe);
         ld_data  = 16'h5A5A;
         tick();
         lat++;
         commit   = 1'b0;
         ld_valid = 1'b0;
      end
      while (commit_done !== 1'b1 && lat < 3000) begin
         tick();
         lat++;
      end
      check("commit_lat", lat, N + 3);
      check("done_ready", upd_ready, 1'b1);
      check("done_ucnt", update_count, m_ucnt);
      check("done_bank", bank_sel, m_bank);
      tick();
      check("done_pulse", commit_done, 1'b0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int prev_idx, idx, r;
      logic [W-1:0] delta;

      rst = 1'b1; upd_valid = 1'b0; upd_idx = '0; upd_delta = '0;
      commit = 1'b0; rollback = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;
      model_reset();
      tick();
      tick();
      check("rst_ready", upd_ready, 1'b0);
      check("rst_busy", busy, 1'b1);
      check("rst_done", commit_done, 1'b0);
      check("rst_rd", rd_data, 16'h0000);
      check("rst_bank", bank_sel, 1'b0);
      check_counters("rst");
      rst = 1'b0;
      wait_init();
      rd_check(0);
      rd_check(585);
      rd_check(1169);
      rd_check(1170);

      // Load, single update, commit.
      do_load(7, 16'h0100);
      upd_beat(7, 16'h0010);
      idle(2);
      check_counters("upd7");
      do_commit(1'b0, 1'b0, 7, 1'b0);

      // Back-to-back updates to one index exercise forwarding; commit is poked during COPY.
      upd_beat(3, 16'h0005);
      upd_beat(3, 16'h0005);
      upd_beat(3, 16'hFFFD);
      idle(2);
      check_counters("fwd");
      do_commit(1'b0, 1'b0, 3, 1'b1);

      // Saturation at both rails.
      do_load(9, 16'h7FF0);
      do_load(10, 16'h8010);
      idle(1);
      upd_beat(9, 16'h0100);
      idle(2);
      check_counters("satp");
      upd_beat(10, 16'hFF00);
      idle(2);
      check_counters("satn");
      do_commit(1'b0, 1'b0, 9, 1'b0);
      rd_check(10);

      // Rollback wins over commit; the next plain commit must not pick up the dropped delta.
      upd_beat(4, 16'h0001);
      idle(2);
      do_commit(1'b1, 1'b1, 4, 1'b0);
      do_commit(1'b0, 1'b0, 4, 1'b0);

      // Out-of-range update is dropped and flagged.
      upd_beat(5, 16'h0020);
      upd_beat(1170, 16'h0005);
      idle(2);
      check_counters("oor");

      // Randomized loads then update bursts, compared after commit.
      for (int i = 0; i < 20; i++) begin
         r = int'($urandom_range(0, 9));
         do_load((r < 7) ? int'($urandom_range(0, 15)) : int'($urandom_range(1160, 1172)), W'($urandom));
      end
      idle(1);
      prev_idx = 0;
      for (int i = 0; i < 60; i++) begin
         r = int'($urandom_range(0, 9));
         if (r < 3) idx = prev_idx;
         else if (r < 8) idx = int'($urandom_range(0, 15));
         else idx = int'($urandom_range(1160, 1172));
         if ($urandom_range(0, 1) == 0) delta = W'($urandom);
         else delta = W'($urandom_range(0, 64)) - 16'd32;
         upd_beat(idx, delta);
         prev_idx = idx;
         if ($urandom_range(0, 3) == 0) idle(1);
      end
      idle(2);
      check_counters("rand");
      do_commit(1'b0, 1'b0, 0, 1'b0);
      for (int a = 0; a < 16; a++) rd_check(a);
      for (int a = 1160; a < 1170; a++) rd_check(a);

      // Reset in the middle of COPY, with the bank_sel toggled to 1 beforehand.
      if (m_bank) do_commit(1'b0, 1'b0, 0, 1'b0);
      commit = 1'b1;
      tick();
      commit = 1'b0;
      m_bank = !m_bank;
      repeat (100) tick();
      check("copy_bank", bank_sel, m_bank);
      check("copy_busy", busy, 1'b1);
      rst = 1'b1;
      tick();
      model_reset();
      check("mid_bank", bank_sel, 1'b0);
      check("mid_busy", busy, 1'b1);
      check("mid_ready", upd_ready, 1'b0);
      check_counters("mid");
      rst = 1'b0;
      wait_init();
      rd_check(7);
      do_load(1170, 16'h1234);
      idle(1);
      check_counters("ldoor");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/weight_update_bank.md
# weight_update_bank

Double-buffered DPD weight store that sits on the receiving end of the A-SPSA engine's weight-update stream. It applies signed `weight_delta` values to a shadow bank via a pipelined saturating read-modify-write. On `commit` it swaps shadow and active atomically, then resynchronises the new shadow from the new active bank. The active bank feeds the TDNN DPD datapath through a 1-cycle read port.

## Interface
- `WEIGHT_WIDTH`, 16: signed weight width.
- `NUM_WEIGHTS`, 1170: entries per bank; valid indices are 0..NUM_WEIGHTS-1.
- `ADDR_WIDTH`, 16: width of the index, address and counter ports.

Ports (the clock is `clk`; reset is synchronous, active-high, named `rst`):
- `clk`  in  1  sole clock
- `rst`  in  1  synchronous active-high reset
- `upd_valid`  in  1  update present (driven by engine `weight_update_valid`)
- `upd_idx`  in  ADDR_WIDTH  weight index
- `upd_delta`  in  WEIGHT_WIDTH  signed delta
- `upd_ready`  out  1  update accepted when `upd_valid && upd_ready`
- `commit`  in  1  pulse: publish shadow as active
- `rollback`  in  1  pulse: discard shadow changes
- `ld_valid`  in  1  initial-weight load strobe
- `ld_addr`  in  ADDR_WIDTH  load address
- `ld_data`  in  WEIGHT_WIDTH  load value, written to both banks
- `rd_addr`  in  ADDR_WIDTH  datapath read address
- `rd_data`  out  WEIGHT_WIDTH  active-bank weight
- `bank_sel`  out  1  index of the active bank
- `busy`  out  1  high in any state other than IDLE
- `commit_done`  out  1  1-cycle pulse when COPY finishes
- `update_count`  out  ADDR_WIDTH  updates applied since the last commit/rollback; saturates at all-ones
- `sat_count`  out  ADDR_WIDTH  updates that clipped; saturates; cleared only by `rst`
- `idx_err`  out  1  sticky: out-of-range update or load was dropped; cleared only by `rst`

## Operation
- FSM states: INIT, IDLE, DRAIN, COPY.
- **INIT:** entered on `rst`. Writes 0 to both banks at addresses 0..NUM_WEIGHTS-1, one address per cycle, then goes to IDLE.
- **IDLE:** `upd_ready = !ld_valid`.
  - **Loads:** `ld_valid` with an in-range address writes both banks that cycle. A load has priority over an update in the same cycle.
  - **Updates:** 2-stage pipeline.
    - S1 (accept cycle): read `shadow[idx]`.
    - S2 (next cycle): compute `sum = sext(old) + sext(delta)` at WEIGHT_WIDTH+1 bits, clamp to [-2^(W-1), 2^(W-1)-1], write shadow, increment `update_count`. Increment `sat_count` if the value clamped.
    - **Forwarding:** when S1 and S2 hold the same idx, S2's result replaces the RAM read data. Back-to-back updates to one index must accumulate exactly.
    - **Out-of-range idx:** accepted, not written, not counted; sets `idx_err`.
- **`commit` / `rollback` in IDLE** → DRAIN. If both are asserted in the same cycle, rollback wins.
- **DRAIN:** one cycle; S2 completes. At the end of DRAIN:
  - commit toggles `bank_sel`;
  - both commit and rollback clear `update_count`;
  - the FSM then goes to COPY.
- **COPY:** copies active → shadow for all NUM_WEIGHTS entries (1-cycle RAM read pipeline). Then IDLE with `commit_done` high for that first IDLE cycle.
- `commit` / `rollback` outside IDLE are ignored.
- `ld_valid` outside IDLE is ignored.
- **Read port:** `rd_data` is registered from `active[rd_addr]`, using the active bank as of the cycle `rd_addr` is sampled. An out-of-range `rd_addr` returns 0.
- **`rst` mid-operation:** aborts any pipeline, DRAIN or COPY activity and re-enters INIT. `bank_sel` returns to 0.

## Timing
- **Reset values:**
  - `upd_ready` = 0, `busy` = 1, `commit_done` = 0
  - `rd_data` = 0, `bank_sel` = 0
  - `update_count` = 0, `sat_count` = 0, `idx_err` = 0
- **INIT:** occupies NUM_WEIGHTS cycles after the first cycle with `rst` low. `upd_ready` rises on cycle NUM_WEIGHTS+1 (1171 by default).
- **Update latency:** an update accepted at cycle N is written at the N+1 edge.
  - Visible to `rd_data` only after a commit.
  - Visible to a later update immediately, via forwarding.
- **Commit sampled at cycle C:**
  - An update accepted in the same cycle C is included in the commit.
  - `upd_ready` = 0 and `busy` = 1 from C+1.
  - New `bank_sel` is visible from C+2.
  - COPY runs C+2..C+NUM_WEIGHTS+2.
  - `commit_done` pulses and `upd_ready` returns at C+NUM_WEIGHTS+3 (C+1173 by default).
- **Read port:** 1-cycle latency, with one read per cycle in every state. `rd_data` never shows a partially updated bank.

## Test plan
- **Reset/INIT:** assert `rst` 2 cycles, release → `upd_ready` = 0 for 1170 cycles, then 1. `rd_data` = 0 for addresses 0, 585, 1169.
- **Load + update + commit:**
  - Load addr 7 = 0x0100, then update idx 7 delta +0x0010, then commit.
  - `rd_data`@7 = 0x0100 before `bank_sel` toggles, 0x0110 after.
  - `commit_done` exactly 1173 cycles after commit; `update_count` 1 → 0.
- **Forwarding:** updates idx 3 with deltas +5, +5, -3 on consecutive cycles (base 0), then commit → `rd_data`@3 = 7.
- **Saturation:**
  - idx 9 loaded 0x7FF0, delta +0x0100 → 0x7FFF, `sat_count` = 1.
  - idx 10 loaded 0x8010, delta -0x0100 → 0x8000, `sat_count` = 2.
- **Rollback and priority:**
  - Update idx 4 by +1; assert `commit` and `rollback` together → `bank_sel` unchanged; after COPY, `shadow[4]` equals the active value.
  - `commit` during COPY is ignored (no second toggle).
- **Errors and reset mid-COPY:**
  - Update idx 1170 → `idx_err` = 1, `update_count` unchanged.
  - Assert `rst` mid-COPY → `bank_sel` = 0, INIT restarts, `busy` = 1.
